// File: rtl/sum_pkg.sv
// ============================================================================
// sum_pkg : shared types, defaults and helpers for the sum reduction blocks
// Revision: 1.0
// ============================================================================
`default_nettype none

package sum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int N_DEFAULT = 30;
    localparam int W_DEFAULT = 5;
    localparam int A_DEFAULT = 6;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sum_adder_bank.sv
// ============================================================================
// sum_adder_bank : A independent combinational OW-bit adders, s[k] = a[k]+b[k]
// Revision: 1.0
// ============================================================================
`default_nettype none

module sum_adder_bank #(
    parameter int A  = 6,
    parameter int OW = 10
) (
    input  logic [A-1:0][OW-1:0] a,
    input  logic [A-1:0][OW-1:0] b,
    output logic [A-1:0][OW-1:0] s
);

    generate
        for (genvar k = 0; k < A; k++) begin : g_add
            assign s[k] = a[k] + b[k];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sum_reduce_sched.sv
// ============================================================================
// sum_reduce_sched : multi-cycle N-operand sum over a bank of A shared adders
// Revision: 1.0
// ============================================================================
`default_nettype none

module sum_reduce_sched
    import sum_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int W  = W_DEFAULT,
    parameter int A  = A_DEFAULT,
    parameter int OW = W + clog2(N),
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*W-1:0] nums,
    output logic           busy,
    output logic           done,
    output logic [OW-1:0]  sum,
    output logic [CW-1:0]  cycles
);

    localparam int CNTW = clog2(N + 1);
    // Padded view of the buffer so every pair/carry index stays in range.
    localparam int NB   = N + 2 * A;
    localparam int BIW  = clog2(NB);

    state_t               state;
    state_t               state_next;
    logic [OW-1:0]        work      [N];
    logic [OW-1:0]        work_next [N];
    logic [OW-1:0]        run_next  [N];
    logic [OW-1:0]        ext       [NB];
    logic [CNTW-1:0]      cnt;
    logic [CNTW-1:0]      cnt_next;
    logic [CNTW-1:0]      half;
    logic [CNTW-1:0]      pairs;
    logic [CW-1:0]        pass;
    logic [CW-1:0]        pass_next;
    logic [A-1:0][OW-1:0] add_a;
    logic [A-1:0][OW-1:0] add_b;
    logic [A-1:0][OW-1:0] add_s;

    always_comb begin
        half  = cnt >> 1;
        pairs = (int'(half) > A) ? CNTW'(A) : half;
    end

    generate
        for (genvar i = 0; i < NB; i++) begin : g_ext
            if (i < N) begin : g_live
                assign ext[i] = work[i];
            end else begin : g_pad
                assign ext[i] = '0;
            end
        end

        for (genvar k = 0; k < A; k++) begin : g_route
            assign add_a[k] = (k < int'(pairs)) ? ext[2*k]   : '0;
            assign add_b[k] = (k < int'(pairs)) ? ext[2*k+1] : '0;
        end

        // Pair sums land at the front; leftovers slide down by 'pairs' slots.
        for (genvar i = 0; i < N; i++) begin : g_shift
            logic [OW-1:0] pair_sum;
            if (i < A) begin : g_sum
                assign pair_sum = add_s[i];
            end else begin : g_nosum
                assign pair_sum = '0;
            end
            assign run_next[i] = (i < int'(pairs))       ? pair_sum :
                                 (i < int'(cnt - pairs)) ? ext[BIW'(i) + BIW'(pairs)] :
                                                           '0;
        end
    endgenerate

    sum_adder_bank #(
        .A  (A),
        .OW (OW)
    ) u_bank (
        .a (add_a),
        .b (add_b),
        .s (add_s)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pass_next  = pass;
        work_next  = work;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < N; i++) begin
                        work_next[i] = OW'(nums[i*W +: W]);
                    end
                    cnt_next   = CNTW'(N);
                    pass_next  = '0;
                    state_next = (N == 1) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                work_next = run_next;
                cnt_next  = cnt - pairs;
                pass_next = pass + CW'(1);
                if (cnt_next == CNTW'(1)) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            pass   <= '0;
            sum    <= '0;
            cycles <= '0;
            for (int i = 0; i < N; i++) work[i] <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pass  <= pass_next;
            for (int i = 0; i < N; i++) work[i] <= work_next[i];
            // Result is captured on entry to DONE so it is valid with the pulse.
            if (state_next == ST_DONE) begin
                sum    <= work_next[0];
                cycles <= pass_next;
            end
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_DONE);
    assign done = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sum_reduce_sched.sv
// ============================================================================
// tb_sum_reduce_sched : vector table + scoreboard bench for sum_reduce_sched
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sum_reduce_sched;

    typedef struct {
        logic [15:0] s;
        logic [7:0]  c;
        int          acc;
    } exp_t;

    typedef struct {
        logic [149:0] nums;
        logic [9:0]   exp_sum;
    } vec30_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start30 = 1'b0, start5 = 1'b0, start1 = 1'b0;
    logic [149:0] nums30 = '0;
    logic [24:0]  nums5 = '0;
    logic [4:0]   nums1 = '0;
    logic         busy30, done30, busy5, done5, busy1, done1;
    logic [9:0]   sum30;
    logic [7:0]   sum5;
    logic [4:0]   sum1;
    logic [7:0]   cycles30, cycles5, cycles1;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done30_cnt = 0;
    int   exp30_sum = 0;
    int   exp5_sum = 0;
    int   exp1_sum = 0;
    exp_t q30[$];
    exp_t q5[$];
    exp_t q1[$];

    sum_reduce_sched #(.N(30), .W(5), .A(6)) u_d30 (
        .clk(clk), .rst(rst), .start(start30), .nums(nums30),
        .busy(busy30), .done(done30), .sum(sum30), .cycles(cycles30)
    );
    sum_reduce_sched #(.N(5), .W(5), .A(2)) u_d5 (
        .clk(clk), .rst(rst), .start(start5), .nums(nums5),
        .busy(busy5), .done(done5), .sum(sum5), .cycles(cycles5)
    );
    sum_reduce_sched #(.N(1), .W(5), .A(6)) u_d1 (
        .clk(clk), .rst(rst), .start(start1), .nums(nums1),
        .busy(busy1), .done(done1), .sum(sum1), .cycles(cycles1)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [63:0] act_sum);
        n_cmp++;
        n_bad++;
        $display("FAIL %s_unexpected_done: got done with sum %0d, expected no done", nm, act_sum);
    endtask

    task automatic check_done(input string nm, input exp_t e, input logic [63:0] s,
                              input logic [63:0] c);
        check({nm, "_sum"}, s, 64'(e.s));
        check({nm, "_cycles"}, c, 64'(e.c));
        check({nm, "_latency"}, 64'(cyc - e.acc), 64'(e.c));
    endtask

    function automatic int model_sum30(input logic [149:0] v);
        int acc;
        acc = 0;
        for (int i = 0; i < 30; i++) acc += int'(v[i*5 +: 5]);
        return acc;
    endfunction

    // Scoreboard: push on an accepted start, pop and compare on each done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (done30 === 1'b1) begin
                if (q30.size() == 0) unexpected("d30", 64'(sum30));
                else begin
                    e = q30.pop_front();
                    check_done("d30", e, 64'(sum30), 64'(cycles30));
                    done30_cnt++;
                end
            end
            if (done5 === 1'b1) begin
                if (q5.size() == 0) unexpected("d5", 64'(sum5));
                else begin
                    e = q5.pop_front();
                    check_done("d5", e, 64'(sum5), 64'(cycles5));
                end
            end
            if (done1 === 1'b1) begin
                if (q1.size() == 0) unexpected("d1", 64'(sum1));
                else begin
                    e = q1.pop_front();
                    check_done("d1", e, 64'(sum1), 64'(cycles1));
                end
            end
            if (rst === 1'b1) begin
                q30.delete();
                q5.delete();
                q1.delete();
            end else begin
                e.acc = cyc + 1;
                if (start30 && busy30 === 1'b0) begin
                    e.s = 16'(exp30_sum); e.c = 8'd7; q30.push_back(e);
                end
                if (start5 && busy5 === 1'b0) begin
                    e.s = 16'(exp5_sum); e.c = 8'd3; q5.push_back(e);
                end
                if (start1 && busy1 === 1'b0) begin
                    e.s = 16'(exp1_sum); e.c = 8'd0; q1.push_back(e);
                end
            end
        end
    end

    task automatic run30(input logic [149:0] v, input int exp_sum);
        int busy_cnt;
        @(negedge clk);
        exp30_sum = exp_sum;
        nums30    = v;
        start30   = 1'b1;
        @(negedge clk);
        start30  = 1'b0;
        busy_cnt = 0;
        while (busy30 === 1'b1 && busy_cnt < 40) begin
            busy_cnt++;
            @(negedge clk);
        end
        check("d30_busy_cycles", 64'(busy_cnt), 64'd8);
        check("d30_outstanding", 64'(q30.size()), 64'd0);
    endtask

    vec30_t       tbl [6];
    logic [7:0]   pass5 [4][5];
    logic [149:0] all31, ones, ramp;
    int           cnt_before;
    int           guard;

    initial begin
        for (int i = 0; i < 30; i++) begin
            tbl[0].nums[i*5 +: 5] = 5'd31;
            tbl[1].nums[i*5 +: 5] = 5'(i + 1);
            tbl[2].nums[i*5 +: 5] = 5'd0;
            tbl[3].nums[i*5 +: 5] = (i % 2 == 0) ? 5'd31 : 5'd0;
            tbl[4].nums[i*5 +: 5] = 5'($urandom_range(0, 31));
            tbl[5].nums[i*5 +: 5] = 5'($urandom_range(0, 31));
            all31[i*5 +: 5] = 5'd31;
            ones[i*5 +: 5]  = 5'd1;
            ramp[i*5 +: 5]  = 5'(i + 1);
        end
        tbl[0].exp_sum = 10'd930;
        tbl[1].exp_sum = 10'd465;
        tbl[2].exp_sum = 10'd0;
        tbl[3].exp_sum = 10'd465;
        tbl[4].exp_sum = 10'(model_sum30(tbl[4].nums));
        tbl[5].exp_sum = 10'(model_sum30(tbl[5].nums));
        pass5 = '{'{8'd3, 8'd1, 8'd4, 8'd1, 8'd5},
                  '{8'd4, 8'd5, 8'd5, 8'd0, 8'd0},
                  '{8'd9, 8'd5, 8'd0, 8'd0, 8'd0},
                  '{8'd14, 8'd0, 8'd0, 8'd0, 8'd0}};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("d30_reset_busy", 64'(busy30), 64'd0);
        check("d30_reset_done", 64'(done30), 64'd0);
        check("d30_reset_sum", 64'(sum30), 64'd0);
        check("d30_reset_cycles", 64'(cycles30), 64'd0);
        check("d5_reset_sum", 64'(sum5), 64'd0);
        check("d1_reset_sum", 64'(sum1), 64'd0);

        for (int v = 0; v < 6; v++) run30(tbl[v].nums, int'(tbl[v].exp_sum));

        // N=5, A=2: buffer contents after each pass, odd tail carried down.
        @(negedge clk);
        exp5_sum = 14;
        nums5    = {5'd5, 5'd1, 5'd4, 5'd1, 5'd3};
        start5   = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("d5_pass%0d_buf%0d", k, i), 64'(u_d5.work[i]), 64'(pass5[k][i]));
            end
            @(negedge clk);
        end
        check("d5_idle_after", 64'(busy5), 64'd0);
        check("d5_outstanding", 64'(q5.size()), 64'd0);

        // N=1: straight to DONE.
        @(negedge clk);
        exp1_sum = 17;
        nums1    = 5'd17;
        start1   = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("d1_busy_in_done", 64'(busy1), 64'd1);
        @(negedge clk);
        check("d1_idle_after", 64'(busy1), 64'd0);
        check("d1_outstanding", 64'(q1.size()), 64'd0);

        // start held high; operands flip to all-31 whenever the block is busy.
        cnt_before = done30_cnt;
        exp30_sum  = 30;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            nums30  = (busy30 === 1'b1) ? all31 : ones;
            start30 = 1'b1;
        end
        @(negedge clk);
        start30 = 1'b0;
        guard   = 0;
        while (busy30 === 1'b1 && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        check("d30_hold_start_ops", 64'(done30_cnt - cnt_before), 64'd4);
        check("d30_hold_outstanding", 64'(q30.size()), 64'd0);

        // Reset landing on the edge of pass 4 aborts the operation.
        @(negedge clk);
        exp30_sum = 930;
        nums30    = all31;
        start30   = 1'b1;
        @(negedge clk);
        start30 = 1'b0;
        repeat (2) @(negedge clk);
        check("d30_busy_before_abort", 64'(busy30), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("d30_abort_busy", 64'(busy30), 64'd0);
        check("d30_abort_done", 64'(done30), 64'd0);
        check("d30_abort_sum", 64'(sum30), 64'd0);
        check("d30_abort_cycles", 64'(cycles30), 64'd0);
        rst        = 1'b0;
        cnt_before = done30_cnt;
        repeat (12) @(negedge clk);
        check("d30_no_done_after_abort", 64'(done30_cnt - cnt_before), 64'd0);
        run30(ramp, 465);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no summary by 100000 time units, expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule

`default_nettype wire
